// File: rtl/uart_rcv_fifo.sv
// UART receiver (start, DATA_BITS LSB-first, optional even parity, one stop) feeding a show-ahead FIFO.
// Define UART_RCV_PARITY_EN to include the parity bit and parity_err checking.
module uart_rcv_fifo #(
  parameter int BAUD_DIV   = 2604,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          RX,
  input  logic                          rx_rdy_clr,
  input  logic                          err_clr,
  output logic                          rx_rdy,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt,
  output logic                          frame_err,
  output logic                          overrun,
  output logic                          parity_err
);
  localparam int CNT_W = $clog2(BAUD_DIV);
  localparam int BIT_W = $clog2(DATA_BITS);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] HALF_LD  = CNT_W'(BAUD_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LD  = CNT_W'(BAUD_DIV - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);
  localparam logic [AW:0]      FULL_CNT = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

  // Stage p0/p1: RX synchroniser; vld_pN marks when the synchroniser holds a real pin value
  logic rx_p0, rx_p1, vld_p0, vld_p1, rx_seen_hi, fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_p0      <= 1'b1;
      rx_p1      <= 1'b1;
      vld_p0     <= 1'b0;
      vld_p1     <= 1'b0;
      rx_seen_hi <= 1'b0;
    end else begin
      rx_p0      <= RX;
      rx_p1      <= rx_p0;
      vld_p0     <= 1'b1;
      vld_p1     <= vld_p0;
      rx_seen_hi <= rx_p1 & vld_p1;
    end
  end

  assign fall = rx_seen_hi & ~rx_p1;

  // Frame FSM: counter expiry marks the middle of each bit
  state_t               state, state_d;
  logic [CNT_W-1:0]     baud_cnt, baud_cnt_d;
  logic [BIT_W-1:0]     bit_cnt, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 baud_tick, push, frame_set, par_set;
`ifdef UART_RCV_PARITY_EN
  logic                 par_bad, par_bad_d;
`endif

  assign baud_tick = (baud_cnt == '0);

  always_comb begin
    state_d    = state;
    baud_cnt_d = baud_tick ? baud_cnt : baud_cnt - CNT_W'(1);
    bit_cnt_d  = bit_cnt;
    shift_d    = shift_q;
    push       = 1'b0;
    frame_set  = 1'b0;
    par_set    = 1'b0;
`ifdef UART_RCV_PARITY_EN
    par_bad_d  = par_bad;
`endif
    case (state)
      IDLE: begin
        if (fall) begin
          state_d    = START;
          baud_cnt_d = HALF_LD;
        end
      end
      START: begin
        if (baud_tick) begin
          if (!rx_p1) begin
            state_d    = DATA;
            baud_cnt_d = FULL_LD;
            bit_cnt_d  = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (baud_tick) begin
          shift_d    = {rx_p1, shift_q[DATA_BITS-1:1]};
          baud_cnt_d = FULL_LD;
          if (bit_cnt == LAST_BIT) begin
`ifdef UART_RCV_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt + BIT_W'(1);
          end
        end
      end
`ifdef UART_RCV_PARITY_EN
      PARITY: begin
        if (baud_tick) begin
          par_bad_d  = (^shift_q) ^ rx_p1;
          baud_cnt_d = FULL_LD;
          state_d    = STOP;
        end
      end
`endif
      STOP: begin
        if (baud_tick) begin
`ifdef UART_RCV_PARITY_EN
          par_set = par_bad;
`endif
          if (rx_p1) begin
            push    = 1'b1;
            state_d = IDLE;
          end else begin
            frame_set = 1'b1;
            state_d   = BREAK;
          end
        end
      end
      BREAK: begin
        if (rx_p1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
`ifdef UART_RCV_PARITY_EN
      par_bad  <= 1'b0;
`endif
    end else begin
      state    <= state_d;
      baud_cnt <= baud_cnt_d;
      bit_cnt  <= bit_cnt_d;
`ifdef UART_RCV_PARITY_EN
      par_bad  <= par_bad_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  // Show-ahead FIFO: a pop frees the slot a same-cycle push into a full FIFO needs
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic                 full, pop_ok, push_ok;

  assign full    = (fifo_cnt == FULL_CNT);
  assign rx_rdy  = (fifo_cnt != '0);
  assign pop_ok  = rx_rdy_clr & rx_rdy;
  assign push_ok = push & (~full | pop_ok);
  assign rx_data = rx_rdy ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= shift_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   fifo_cnt <= fifo_cnt + (AW + 1)'(1);
        2'b01:   fifo_cnt <= fifo_cnt - (AW + 1)'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Sticky flags: a set in the same cycle as err_clr wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= frame_set | (frame_err & ~err_clr);
      overrun   <= (push & full & ~pop_ok) | (overrun & ~err_clr);
    end
  end

`ifdef UART_RCV_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) parity_err <= 1'b0;
    else        parity_err <= par_set | (parity_err & ~err_clr);
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rcv_fifo.sv
// Bench for uart_rcv_fifo: frame-level queue model checked every cycle, plus literal spot checks.
module tb_uart_rcv_fifo;
  localparam int B     = 20;
  localparam int DB    = 8;
  localparam int DEPTH = 4;
`ifdef UART_RCV_PARITY_EN
  localparam int P       = 1;
  localparam int LAT_LIT = 213;
`else
  localparam int P       = 0;
  localparam int LAT_LIT = 193;
`endif
  localparam int LAT = 3 + B / 2 + (DB + 1 + P) * B;

  logic       clk, rst_n, RX, rx_rdy_clr, err_clr;
  logic       rx_rdy, frame_err, overrun, parity_err;
  logic [7:0] rx_data;
  logic [2:0] fifo_cnt;

  uart_rcv_fifo #(.BAUD_DIV(B), .DATA_BITS(DB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .RX(RX), .rx_rdy_clr(rx_rdy_clr), .err_clr(err_clr),
    .rx_rdy(rx_rdy), .rx_data(rx_data), .fifo_cnt(fifo_cnt),
    .frame_err(frame_err), .overrun(overrun), .parity_err(parity_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame outcomes scheduled by the driver at the stop-sample edge: 0 push, 1 framing, 2 parity
  typedef struct {
    int         edge_no;
    int         kind;
    logic [7:0] d;
  } ev_t;

  ev_t        evq[$];
  logic [7:0] mq[$];
  bit         m_fe, m_ov, m_pe;
  bit         m_pop, m_push, fe_s, ov_s, pe_s;
  logic [7:0] m_pd, pd_tmp;
  logic [6:0] exp_stat, act_stat;
  int         cyc = 0, n_cmp = 0, n_fail = 0;
  int         last_t0 = 0, rise_cyc = -1;
  bit         prev_rdy = 1'b0;
  bit         rand_pop = 1'b0, rand_clr = 1'b0, pop_at_push = 1'b0;

  task automatic finish_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      if (n_fail >= 50) finish_run();
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
        mq.delete();
        evq.delete();
        m_fe = 1'b0; m_ov = 1'b0; m_pe = 1'b0;
      end else begin
        m_pop  = rx_rdy_clr && (mq.size() > 0);
        m_push = 1'b0; fe_s = 1'b0; ov_s = 1'b0; pe_s = 1'b0; m_pd = '0;
        for (int i = evq.size() - 1; i >= 0; i--) begin
          if (evq[i].edge_no == cyc) begin
            case (evq[i].kind)
              0:       begin m_push = 1'b1; m_pd = evq[i].d; end
              1:       fe_s = 1'b1;
              default: pe_s = 1'b1;
            endcase
            evq.delete(i);
          end
        end
        if (m_pop) void'(mq.pop_front());
        if (m_push) begin
          if (mq.size() < DEPTH) mq.push_back(m_pd);
          else                   ov_s = 1'b1;
        end
        m_fe = fe_s | (m_fe & !err_clr);
        m_ov = ov_s | (m_ov & !err_clr);
        m_pe = pe_s | (m_pe & !err_clr);
      end
      #1;
      exp_stat = {mq.size() > 0, 3'(mq.size()), m_fe, m_ov, m_pe};
      act_stat = {rx_rdy, fifo_cnt, frame_err, overrun, parity_err};
      check("status{rdy,cnt,fe,ov,pe}", 32'(act_stat), 32'(exp_stat));
      if (mq.size() > 0) check("rx_data", 32'(rx_data), 32'(mq[0]));
      if (rx_rdy && !prev_rdy) rise_cyc = cyc;
      prev_rdy = rx_rdy;
    end
  end

  initial begin
    #900000;
    n_fail++;
    $display("FAIL watchdog: run exceeded its cycle budget at cycle %0d", cyc);
    finish_run();
  end

  task automatic tick();
    @(posedge clk);
    #1;
    rx_rdy_clr = rand_pop ? ($urandom_range(0, 3) == 0) : 1'b0;
    err_clr    = rand_clr ? ($urandom_range(0, 15) == 0) : 1'b0;
  endtask

  task automatic tick_p(input int t0);
    tick();
    if (pop_at_push && (cyc + 1 == t0 + LAT)) rx_rdy_clr = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop_ok, input bit par_flip,
                            input int low_hold, input int gap);
    logic [10:0] bits;
    int nb, t0;
    bits    = '1;
    bits[0] = 1'b0;
    bits[8:1] = d;
    if (P == 1) begin
      bits[9]  = (^d) ^ par_flip;
      bits[10] = stop_ok;
    end else begin
      bits[9] = stop_ok;
    end
    nb = 10 + P;
    tick();
    RX = 1'b0;
    t0 = cyc;
    last_t0 = t0;
    evq.push_back('{edge_no: t0 + LAT, kind: stop_ok ? 0 : 1, d: d});
    if (P == 1 && par_flip) evq.push_back('{edge_no: t0 + LAT, kind: 2, d: d});
    for (int b = 1; b < nb; b++) begin
      repeat (B) tick_p(t0);
      RX = bits[b];
    end
    repeat (B) tick_p(t0);
    if (!stop_ok) begin
      repeat (low_hold) tick();
      RX = 1'b1;
    end
    repeat (gap) tick();
  endtask

  task automatic glitch(input int len);
    tick();
    RX = 1'b0;
    repeat (len) tick();
    RX = 1'b1;
    repeat (20) tick();
  endtask

  task automatic pop_one(output logic [7:0] d);
    d = rx_data;
    rx_rdy_clr = 1'b1;
    tick();
  endtask

  task automatic pulse_err_clr();
    err_clr = 1'b1;
    tick();
    tick();
  endtask

  initial begin
    RX = 1'b1; rx_rdy_clr = 1'b0; err_clr = 1'b0; rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("reset rx_rdy", 32'(rx_rdy), 32'd0);
    check("reset fifo_cnt", 32'(fifo_cnt), 32'd0);
    check("reset rx_data", 32'(rx_data), 32'd0);
    check("reset flags", 32'({frame_err, overrun, parity_err}), 32'd0);

    // First frame into an empty FIFO: exact pin-to-rx_rdy latency
    rise_cyc = -1;
    send_frame(8'h96, 1'b1, 1'b0, 0, 20);
    check("latency", 32'(rise_cyc - last_t0), 32'(LAT_LIT));
    pop_one(pd_tmp);
    check("pop 0x96", 32'(pd_tmp), 32'h96);

    // Short low glitch is rejected at the start-bit sample
    glitch(6);
    check("glitch no push", 32'(fifo_cnt), 32'd0);
    check("glitch flags", 32'({frame_err, overrun, parity_err}), 32'd0);
    send_frame(8'hA5, 1'b1, 1'b0, 0, 20);
    pop_one(pd_tmp);
    check("pop 0xA5", 32'(pd_tmp), 32'hA5);

    // Low stop bit, held-low line, then a good frame
    send_frame(8'h3C, 1'b0, 1'b0, 3 * B, 20);
    send_frame(8'h5A, 1'b1, 1'b0, 0, 20);
    check("framing frame_err", 32'(frame_err), 32'd1);
    check("framing fifo_cnt", 32'(fifo_cnt), 32'd1);
    pop_one(pd_tmp);
    check("pop 0x5A", 32'(pd_tmp), 32'h5A);
    pulse_err_clr();
    check("frame_err cleared", 32'(frame_err), 32'd0);

    // Overrun: fifth word dropped
    send_frame(8'h11, 1'b1, 1'b0, 0, 20);
    send_frame(8'h22, 1'b1, 1'b0, 0, 20);
    send_frame(8'h33, 1'b1, 1'b0, 0, 20);
    send_frame(8'h44, 1'b1, 1'b0, 0, 20);
    send_frame(8'h55, 1'b1, 1'b0, 0, 20);
    check("overrun fifo_cnt", 32'(fifo_cnt), 32'd4);
    check("overrun flag", 32'(overrun), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      pop_one(pd_tmp);
      check("overrun pop", 32'(pd_tmp), 32'(i * 8'h11));
    end
    pulse_err_clr();
    check("overrun cleared", 32'(overrun), 32'd0);

    // Full FIFO with a pop in the push cycle
    send_frame(8'h61, 1'b1, 1'b0, 0, 20);
    send_frame(8'h62, 1'b1, 1'b0, 0, 20);
    send_frame(8'h63, 1'b1, 1'b0, 0, 20);
    send_frame(8'h64, 1'b1, 1'b0, 0, 20);
    pop_at_push = 1'b1;
    send_frame(8'h66, 1'b1, 1'b0, 0, 20);
    pop_at_push = 1'b0;
    check("full+pop fifo_cnt", 32'(fifo_cnt), 32'd4);
    check("full+pop overrun", 32'(overrun), 32'd0);
    repeat (4) pop_one(pd_tmp);
    check("full+pop last out", 32'(pd_tmp), 32'h66);

`ifdef UART_RCV_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b0, 0, 20);
    check("parity good", 32'(parity_err), 32'd0);
    send_frame(8'h07, 1'b1, 1'b1, 0, 20);
    check("parity bad", 32'(parity_err), 32'd1);
    check("parity both pushed", 32'(fifo_cnt), 32'd2);
    repeat (2) pop_one(pd_tmp);
    check("parity word", 32'(pd_tmp), 32'h07);
    pulse_err_clr();
`endif

    // Randomized frames, glitches, framing errors, pops and error clears
    rand_pop = 1'b1;
    rand_clr = 1'b1;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 9) == 0) glitch($urandom_range(1, 8));
      send_frame(8'($urandom_range(0, 255)), $urandom_range(0, 7) != 0,
                 $urandom_range(0, 5) == 0, $urandom_range(0, 2 * B),
                 $urandom_range(2, 30));
    end
    rand_pop = 1'b0;
    rand_clr = 1'b0;
    tick();
    while (rx_rdy) pop_one(pd_tmp);
    pulse_err_clr();

    // Reset during DATA with two words queued
    send_frame(8'h81, 1'b1, 1'b0, 0, 20);
    send_frame(8'h82, 1'b1, 1'b0, 0, 20);
    check("pre-reset fifo_cnt", 32'(fifo_cnt), 32'd2);
    tick();
    RX = 1'b0;
    repeat (4 * B) tick();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post-reset status", 32'({rx_rdy, fifo_cnt, frame_err, overrun, parity_err}), 32'd0);
    check("post-reset rx_data", 32'(rx_data), 32'd0);
    repeat (5 * B) tick();
    RX = 1'b1;
    repeat (2 * B) tick();
    check("no frame while low", 32'(fifo_cnt), 32'd0);
    send_frame(8'hC3, 1'b1, 1'b0, 0, 20);
    pop_one(pd_tmp);
    check("pop 0xC3", 32'(pd_tmp), 32'hC3);
    repeat (5) tick();
    finish_run();
  end
endmodule
